// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver.
// The rx line is double-flopped into the clock domain. A small FSM samples each bit
// at mid-bit using a 16-bit down-counter, which is reloaded on entry to every state
// (and for every data bit) and fires at terminal count zero.
//
// state   | meaning
// --------+---------------------------------------------------------------
// idle    | line idle, waiting for rxs to go low
// start   | half a bit after the falling edge; re-check the start bit
// data    | sample 8 data bits, one per bit time, LSB first
// stop    | sample the stop bit; publish the byte or flag a framing error
// waith   | framing error seen; wait for the line to return high
//
// Decisions are registered, so rcv/ferr rise one clock after the stop-bit sample.
// With two synchroniser flops, rcv rises H+9*BAUDRATE+3 clocks after the pin falls.
// The FSM returns to idle at mid-stop-bit, so back-to-back frames need no idle gap.

module uart_rx #(
    parameter int BAUDRATE = 104   // clk cycles per serial bit (115200 baud at 12 MHz); 4..65535
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       rx,
    output logic [7:0] data,
    output logic       rcv,
    output logic       ferr,
    output logic       busy
);

    // Reload values: the counter counts down to zero, so a reload of N-1 fires
    // on the N-th cycle spent in the state.
    localparam logic [15:0] half_m1 = 16'((BAUDRATE >> 1) - 1);
    localparam logic [15:0] baud_m1 = 16'(BAUDRATE - 1);

    typedef enum logic [2:0] {
        st_idle,
        st_start,
        st_data,
        st_stop,
        st_waith
    } state_t;

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [2:0]  bit_idx, bit_idx_nxt;
    logic [7:0]  shreg, shreg_nxt;
    logic [7:0]  data_nxt;
    logic        rcv_nxt;
    logic        ferr_nxt;
    logic        rx_meta;
    logic        rxs;
    logic        tc;

    // Two-flop synchroniser; resets to the idle-high line level.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // State register plus baud counter, shift register and registered outputs.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state   <= st_idle;
            cnt     <= 16'd0;
            bit_idx <= 3'd0;
            shreg   <= 8'h00;
            data    <= 8'h00;
            rcv     <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            bit_idx <= bit_idx_nxt;
            shreg   <= shreg_nxt;
            data    <= data_nxt;
            rcv     <= rcv_nxt;
            ferr    <= ferr_nxt;
        end
    end

    assign tc = (cnt == 16'd0);

    // Next-state logic: counter reloads, bit shifting and strobe generation.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = tc ? cnt : cnt - 16'd1;
        bit_idx_nxt = bit_idx;
        shreg_nxt   = shreg;
        data_nxt    = data;
        rcv_nxt     = 1'b0;
        ferr_nxt    = 1'b0;

        case (state)
            st_idle: begin
                if (!rxs) begin
                    state_nxt   = st_start;
                    cnt_nxt     = half_m1;
                    bit_idx_nxt = 3'd0;
                end
            end
            st_start: begin
                if (tc) begin
                    if (rxs) begin
                        // Line went back high before mid-start-bit: a glitch.
                        state_nxt = st_idle;
                    end else begin
                        state_nxt   = st_data;
                        cnt_nxt     = baud_m1;
                        bit_idx_nxt = 3'd0;
                    end
                end
            end
            st_data: begin
                if (tc) begin
                    shreg_nxt = {rxs, shreg[7:1]};
                    cnt_nxt   = baud_m1;
                    if (bit_idx == 3'd7) begin
                        state_nxt = st_stop;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end
            end
            st_stop: begin
                if (tc) begin
                    if (rxs) begin
                        data_nxt  = shreg;
                        rcv_nxt   = 1'b1;
                        state_nxt = st_idle;
                    end else begin
                        ferr_nxt  = 1'b1;
                        state_nxt = st_waith;
                    end
                end
            end
            st_waith: begin
                // Hold off on a break or stuck-low line until it recovers.
                if (rxs) begin
                    state_nxt = st_idle;
                end
            end
            default: begin
                state_nxt = st_idle;
            end
        endcase
    end

    assign busy = (state != st_idle);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: drives ideal 8N1 frames into uart_rx; expected bytes (with the cycle of
// their start-bit fall) go into a scoreboard queue and are compared on every rcv.
`timescale 1ns/1ps

module tb_uart_rx;

    localparam int BAUD = 104;
    localparam int H    = BAUD >> 1;
    localparam int LAT  = H + 9 * BAUD + 3;

    logic       clk  = 1'b0;
    logic       rstn = 1'b0;
    logic       rx   = 1'b1;
    logic [7:0] data;
    logic       rcv;
    logic       ferr;
    logic       busy;

    uart_rx #(.BAUDRATE(BAUD)) dut (
        .clk  (clk),
        .rstn (rstn),
        .rx   (rx),
        .data (data),
        .rcv  (rcv),
        .ferr (ferr),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] b;
        int         fall;
    } exp_t;

    exp_t sb[$];
    exp_t e_mon;

    int checks    = 0;
    int failures  = 0;
    int rcv_cnt   = 0;
    int ferr_cnt  = 0;
    int sent_cnt  = 0;
    int exp_ferr  = 0;
    bit act_seen  = 1'b0;
    bit rstn_prev = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Output monitor: scoreboard compare on rcv, strobe accounting, data stability.
    always @(negedge clk) begin
        if (rstn) begin
            if (rcv || ferr || busy) act_seen = 1'b1;
            if (rcv) begin
                rcv_cnt++;
                check_val("rcv_ferr_excl", 32'({rcv, ferr}), 32'h2);
                if (sb.size() > 0) begin
                    e_mon = sb.pop_front();
                    check_val("rcv_data", 32'(data), 32'(e_mon.b));
                    check_val("rcv_latency", 32'(cyc - e_mon.fall), 32'(LAT));
                end
            end
            if (ferr) ferr_cnt++;
            if (rstn_prev && !rcv && data !== prev_data)
                check_val("data_stable", 32'(data), 32'(prev_data));
        end
        rstn_prev = rstn;
        prev_data = data;
    end

    // Hold rx at v for one bit time; entered and left just after a rising edge.
    task automatic rx_drive(input logic v);
        rx = v;
        repeat (BAUD) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_val);
        exp_t e;
        if (stop_val) begin
            e.b    = b;
            e.fall = cyc;
            sb.push_back(e);
            sent_cnt++;
        end
        rx_drive(1'b0);
        for (int i = 0; i < 8; i++) rx_drive(b[i]);
        rx_drive(stop_val);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic phase_end(input string tag);
        idle(20);
        check_val({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
        check_val({tag, "_rcv_count"}, 32'(rcv_cnt), 32'(sent_cnt));
        check_val({tag, "_ferr_count"}, 32'(ferr_cnt), 32'(exp_ferr));
    endtask

    initial begin
        string s_hola;
        string s_loop;
        int    gfall;

        s_hola = "Hola";
        s_loop = "Loopback!?";

        // 1. reset and long idle
        rstn = 1'b0;
        rx   = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_data", 32'(data), 32'h00);
        check_val("rst_rcv", 32'(rcv), 32'd0);
        check_val("rst_ferr", 32'(ferr), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        rstn = 1'b1;
        act_seen = 1'b0;
        idle(2000);
        check_val("idle_activity", 32'(act_seen), 32'd0);
        check_val("idle_data", 32'(data), 32'h00);

        // 2. single byte with latency check in the monitor
        send_byte(8'h55, 1'b1);
        phase_end("b55");
        check_val("b55_data", 32'(data), 32'h55);

        // 3. back-to-back string
        for (int i = 0; i < 4; i++) send_byte(s_hola[i], 1'b1);
        phase_end("hola");
        check_val("hola_last", 32'(data), 32'h61);

        // 4. 20-cycle glitch
        gfall = cyc;
        rx = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check_val("glitch_busy_hi", 32'(busy), 32'd1);
        @(posedge clk);
        repeat (9) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (gfall + H + 4 - cyc) @(posedge clk);
        @(negedge clk);
        check_val("glitch_busy_lo", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        idle(30);
        check_val("glitch_no_rcv", 32'(rcv_cnt), 32'(sent_cnt));
        send_byte(8'h31, 1'b1);
        phase_end("glitch");
        check_val("after_glitch", 32'(data), 32'h31);

        // 5. framing error, line held low
        send_byte(8'hA3, 1'b0);
        exp_ferr++;
        rx = 1'b0;
        repeat (2 * BAUD) @(posedge clk);
        @(negedge clk);
        check_val("ferr_busy_hold", 32'(busy), 32'd1);
        check_val("ferr_data_kept", 32'(data), 32'h31);
        check_val("ferr_pulse", 32'(ferr_cnt), 32'(exp_ferr));
        @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_val("ferr_busy_rel", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        idle(20);
        send_byte(8'h41, 1'b1);
        phase_end("ferr");
        check_val("after_ferr", 32'(data), 32'h41);

        // 6. reset after the 4th data bit of 0x0F
        rx_drive(1'b0);
        for (int i = 0; i < 4; i++) rx_drive(1'b1);
        rstn = 1'b0;
        rx   = 1'b1;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        check_val("midrst_busy", 32'(busy), 32'd0);
        check_val("midrst_data", 32'(data), 32'h00);
        idle(3 * BAUD);
        send_byte(8'h7E, 1'b1);
        phase_end("midrst");
        check_val("after_rst", 32'(data), 32'h7E);

        // 7. transmitter model streaming a 10-character string with small gaps
        for (int i = 0; i < 10; i++) begin
            send_byte(s_loop[i], 1'b1);
            idle(int'($urandom_range(3, 0)));
        end
        phase_end("loop");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit as a safety net.
    initial begin
        #5_000_000;
        check_val("timeout", 32'd1, 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "time limit");
    end

endmodule
